timer_tick_scheduler: RTL and testbench

Sequencing controller that owns the system interval timer's 16-bit register slave as its sole Avalon-MM master. It programs and starts the timer after reset, acknowledges every timeout interrupt and turns it into a 32-bit tick count plus divided per-channel tick strobes for downstream logic. It also serves snapshot requests by latching and reading back the live counter. It sits between the timer slave and the tick consumers, replacing software servicing of the timer.

---
 rtl/timer_tick_scheduler_if.sv | 27 ++
 rtl/timer_tick_scheduler.sv | 179 +++++++++++++++++
 tb/tb_timer_tick_scheduler.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/timer_tick_scheduler_if.sv
// rtl/timer_tick_scheduler_if.sv - Avalon-MM link between the tick scheduler and the interval timer slave.
interface timer_tick_scheduler_if;
    logic [2:0]  tm_address;
    logic        tm_chipselect;
    logic        tm_write_n;
    logic [15:0] tm_writedata;
    logic [15:0] tm_readdata;
    logic        tm_irq;

    modport master (
        output tm_address,
        output tm_chipselect,
        output tm_write_n,
        output tm_writedata,
        input  tm_readdata,
        input  tm_irq
    );

    modport slave (
        input  tm_address,
        input  tm_chipselect,
        input  tm_write_n,
        input  tm_writedata,
        output tm_readdata,
        output tm_irq
    );
endinterface

// File: rtl/timer_tick_scheduler.sv
// rtl/timer_tick_scheduler.sv - Sole bus master of the interval timer: init, timeout ack, tick division, snapshots.
module timer_tick_scheduler #(
    parameter logic [31:0]        PERIOD = 32'd99,
    parameter int                 N_CH   = 4,
    parameter logic [8*N_CH-1:0]  CH_DIV = 32'h0A050201
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   run,
    input  logic                   snap_req,
    timer_tick_scheduler_if.master tm,
    output logic                   running,
    output logic                   busy,
    output logic [N_CH-1:0]        tick,
    output logic [31:0]            tick_count,
    output logic                   snap_valid,
    output logic [31:0]            snap_value
);

    typedef enum logic [3:0] {
        IDLE, STOP_W, PL_W, PH_W, CLR_W, CTL_W, RUN, ACK_W, ACK_GAP,
        SNAP_W, SNAP_RL, SNAP_RH, SNAP_CAP, HALT_W
    } state_t;

    state_t      state_q, state_d;
    logic        snap_pend_q, snap_pend_d;
    logic [2:0]  addr_q, addr_d;
    logic        cs_q, cs_d;
    logic        wn_q, wn_d;
    logic [15:0] wd_q, wd_d;
    logic        running_q, running_d;
    logic        busy_q, busy_d;
    logic [N_CH-1:0] tick_q, tick_d;
    logic [31:0] tick_count_q, tick_count_d;
    logic        snap_valid_q;
    logic [31:0] snap_value_q;
    logic [7:0]  ch_cnt_q [N_CH];
    logic [7:0]  ch_cnt_d [N_CH];
    logic        ack_entry, idle_entry;

    // A zero divisor behaves like one, so its terminal count is also zero.
    function automatic logic [7:0] div_m1(input int ch);
        logic [7:0] d;
        d = CH_DIV[8*ch +: 8];
        return (d == 8'd0) ? 8'd0 : d - 8'd1;
    endfunction

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (run) state_d = STOP_W;
            STOP_W:   state_d = PL_W;
            PL_W:     state_d = PH_W;
            PH_W:     state_d = CLR_W;
            CLR_W:    state_d = CTL_W;
            CTL_W:    state_d = RUN;
            RUN: begin
                if (!run)             state_d = HALT_W;
                else if (tm.tm_irq)   state_d = ACK_W;
                else if (snap_pend_q) state_d = SNAP_W;
            end
            ACK_W:    state_d = ACK_GAP;
            ACK_GAP:  state_d = RUN;
            SNAP_W:   state_d = SNAP_RL;
            SNAP_RL:  state_d = SNAP_RH;
            SNAP_RH:  state_d = SNAP_CAP;
            SNAP_CAP: state_d = RUN;
            HALT_W:   state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Bus outputs are decoded from the next state so they are registered yet aligned with it.
    always_comb begin
        cs_d   = 1'b0;
        wn_d   = 1'b1;
        addr_d = 3'd0;
        wd_d   = 16'd0;
        case (state_d)
            STOP_W:  begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd1; wd_d = 16'h0008;        end
            PL_W:    begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd2; wd_d = PERIOD[15:0];    end
            PH_W:    begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd3; wd_d = PERIOD[31:16];   end
            CLR_W:   begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd0;                         end
            CTL_W:   begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd1; wd_d = 16'h0007;        end
            ACK_W:   begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd0;                         end
            SNAP_W:  begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd4;                         end
            SNAP_RL: begin cs_d = 1'b1;              addr_d = 3'd4;                         end
            SNAP_RH: begin cs_d = 1'b1;              addr_d = 3'd5;                         end
            HALT_W:  begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd1; wd_d = 16'h0008;        end
            default: ;
        endcase
    end

    always_comb begin
        running_d = 1'b0;
        case (state_d)
            RUN, ACK_W, ACK_GAP, SNAP_W, SNAP_RL, SNAP_RH, SNAP_CAP: running_d = 1'b1;
            default: ;
        endcase
        busy_d = (state_d != IDLE) && (state_d != RUN);
    end

    assign ack_entry  = (state_d == ACK_W) && (state_q != ACK_W);
    assign idle_entry = (state_d == IDLE) && (state_q != IDLE);

    always_comb begin
        tick_d       = '0;
        tick_count_d = ack_entry ? tick_count_q + 32'd1 : tick_count_q;
        for (int i = 0; i < N_CH; i++) begin
            ch_cnt_d[i] = ch_cnt_q[i];
            if (idle_entry) begin
                ch_cnt_d[i] = 8'd0;
            end else if (ack_entry) begin
                if (ch_cnt_q[i] == div_m1(i)) begin
                    ch_cnt_d[i] = 8'd0;
                    tick_d[i]   = 1'b1;
                end else begin
                    ch_cnt_d[i] = ch_cnt_q[i] + 8'd1;
                end
            end
        end
    end

    // IDLE entry wins so a request racing a halt is never carried into the next run.
    always_comb begin
        snap_pend_d = snap_pend_q;
        if (idle_entry)
            snap_pend_d = 1'b0;
        else if (snap_req && (state_q != IDLE))
            snap_pend_d = 1'b1;
        else if (state_d == SNAP_W && state_q != SNAP_W)
            snap_pend_d = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            snap_pend_q  <= 1'b0;
            addr_q       <= 3'd0;
            cs_q         <= 1'b0;
            wn_q         <= 1'b1;
            wd_q         <= 16'd0;
            running_q    <= 1'b0;
            busy_q       <= 1'b0;
            tick_q       <= '0;
            tick_count_q <= 32'd0;
            snap_valid_q <= 1'b0;
            snap_value_q <= 32'd0;
            for (int i = 0; i < N_CH; i++) ch_cnt_q[i] <= 8'd0;
        end else begin
            state_q      <= state_d;
            snap_pend_q  <= snap_pend_d;
            addr_q       <= addr_d;
            cs_q         <= cs_d;
            wn_q         <= wn_d;
            wd_q         <= wd_d;
            running_q    <= running_d;
            busy_q       <= busy_d;
            tick_q       <= tick_d;
            tick_count_q <= tick_count_d;
            snap_valid_q <= (state_q == SNAP_CAP);
            if (state_q == SNAP_RH)  snap_value_q[15:0]  <= tm.tm_readdata;
            if (state_q == SNAP_CAP) snap_value_q[31:16] <= tm.tm_readdata;
            for (int i = 0; i < N_CH; i++) ch_cnt_q[i] <= ch_cnt_d[i];
        end
    end

    assign tm.tm_address    = addr_q;
    assign tm.tm_chipselect = cs_q;
    assign tm.tm_write_n    = wn_q;
    assign tm.tm_writedata  = wd_q;
    assign running          = running_q;
    assign busy             = busy_q;
    assign tick             = tick_q;
    assign tick_count       = tick_count_q;
    assign snap_valid       = snap_valid_q;
    assign snap_value       = snap_value_q;

endmodule

// File: tb/tb_timer_tick_scheduler.sv
// tb/tb_timer_tick_scheduler.sv - Vector and sequence bench for timer_tick_scheduler.
module tb_timer_tick_scheduler;

    logic        clk = 1'b0;
    logic        reset, run, snap_req;
    logic        running, busy, snap_valid;
    logic [3:0]  tick;
    logic [31:0] tick_count, snap_value;
    logic [31:0] live_cnt, snap_latch;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          ack_writes = 0;
    int          tick_seen [4] = '{0, 0, 0, 0};

    timer_tick_scheduler_if tm_bus ();

    timer_tick_scheduler #(
        .PERIOD (32'd99),
        .N_CH   (4),
        .CH_DIV (32'h0A050201)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .snap_req   (snap_req),
        .tm         (tm_bus.master),
        .running    (running),
        .busy       (busy),
        .tick       (tick),
        .tick_count (tick_count),
        .snap_valid (snap_valid),
        .snap_value (snap_value)
    );

    always #5 clk = ~clk;

    // Timer slave: snap latch on write to reg4, registered read data.
    always @(posedge clk) begin
        if (reset) begin
            tm_bus.tm_readdata <= 16'd0;
        end else begin
            if (tm_bus.tm_chipselect && !tm_bus.tm_write_n && tm_bus.tm_address == 3'd4)
                snap_latch <= live_cnt;
            if (tm_bus.tm_chipselect && tm_bus.tm_write_n && tm_bus.tm_address == 3'd4)
                tm_bus.tm_readdata <= snap_latch[15:0];
            else if (tm_bus.tm_chipselect && tm_bus.tm_write_n && tm_bus.tm_address == 3'd5)
                tm_bus.tm_readdata <= snap_latch[31:16];
            else
                tm_bus.tm_readdata <= 16'd0;
        end
    end

    always @(negedge clk) begin
        if (tm_bus.tm_chipselect && !tm_bus.tm_write_n && tm_bus.tm_address == 3'd0)
            ack_writes <= ack_writes + 1;
        for (int i = 0; i < 4; i++)
            if (tick[i]) tick_seen[i] <= tick_seen[i] + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [4:0] bus5();
        return {tm_bus.tm_chipselect, tm_bus.tm_write_n, tm_bus.tm_address};
    endfunction

    task automatic check_reset_vals(input string tag);
        check({tag, ".bus"},        {27'd0, bus5()}, 32'h08);
        check({tag, ".wdata"},      {16'd0, tm_bus.tm_writedata}, 32'd0);
        check({tag, ".run_busy"},   {30'd0, running, busy}, 32'd0);
        check({tag, ".tick"},       {28'd0, tick}, 32'd0);
        check({tag, ".tick_count"}, tick_count, 32'd0);
        check({tag, ".snap_valid"}, {31'd0, snap_valid}, 32'd0);
        check({tag, ".snap_value"}, snap_value, 32'd0);
    endtask

    task automatic do_timeout(input int n, input logic [31:0] exp_count);
        logic found;
        found = 1'b0;
        @(negedge clk);
        tm_bus.tm_irq = 1'b1;
        for (int k = 0; k < 10 && !found; k++) begin
            @(posedge clk); #1;
            if (bus5() == 5'b10000) found = 1'b1;
        end
        tm_bus.tm_irq = 1'b0;
        check($sformatf("to%0d.ack_seen", n), {31'd0, found}, 32'd1);
        check($sformatf("to%0d.tick", n), {28'd0, tick},
              {28'd0, (n % 10 == 0), (n % 5 == 0), (n % 2 == 0), 1'b1});
        check($sformatf("to%0d.count", n), tick_count, exp_count);
        @(posedge clk); #1;
        check($sformatf("to%0d.tick_strobe", n), {28'd0, tick}, 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic find_snap_w(input string tag);
        logic found;
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(posedge clk); #1;
            if (bus5() == 5'b10100) found = 1'b1;
        end
        check({tag, ".snap_w_seen"}, {31'd0, found}, 32'd1);
    endtask

    task automatic snap_tail(input string tag, input logic [31:0] val);
        check({tag, ".valid_s"}, {31'd0, snap_valid}, 32'd0);
        @(posedge clk); #1;
        check({tag, ".rl_bus"}, {27'd0, bus5()}, 32'h1C);
        @(posedge clk); #1;
        check({tag, ".rh_bus"}, {27'd0, bus5()}, 32'h1D);
        @(posedge clk); #1;
        check({tag, ".cap_bus"}, {27'd0, bus5()}, 32'h08);
        check({tag, ".valid_s3"}, {31'd0, snap_valid}, 32'd0);
        @(posedge clk); #1;
        check({tag, ".valid_s4"}, {31'd0, snap_valid}, 32'd1);
        check({tag, ".value"}, snap_value, val);
        @(posedge clk); #1;
        check({tag, ".valid_s5"}, {31'd0, snap_valid}, 32'd0);
    endtask

    task automatic do_snap(input string tag, input logic [31:0] val);
        @(negedge clk);
        live_cnt = val;
        snap_req = 1'b1;
        @(posedge clk); #1;
        snap_req = 1'b0;
        find_snap_w(tag);
        snap_tail(tag, val);
    endtask

    typedef struct {
        logic        run;
        logic        irq;
        logic [4:0]  bus;
        logic [15:0] wd;
        logic        running;
        logic        busy;
        logic [3:0]  tick;
        logic [31:0] cnt;
    } vec_t;

    vec_t        vecs [15];
    logic [20:0] halt_seq [6];
    int          base;

    initial begin
        // Init writes, then three timeouts including irq held through ACK_W/ACK_GAP.
        vecs[0]  = '{1'b1, 1'b0, 5'b10001, 16'h0008, 1'b0, 1'b1, 4'h0, 32'd0};
        vecs[1]  = '{1'b1, 1'b0, 5'b10010, 16'h0063, 1'b0, 1'b1, 4'h0, 32'd0};
        vecs[2]  = '{1'b1, 1'b0, 5'b10011, 16'h0000, 1'b0, 1'b1, 4'h0, 32'd0};
        vecs[3]  = '{1'b1, 1'b0, 5'b10000, 16'h0000, 1'b0, 1'b1, 4'h0, 32'd0};
        vecs[4]  = '{1'b1, 1'b0, 5'b10001, 16'h0007, 1'b0, 1'b1, 4'h0, 32'd0};
        vecs[5]  = '{1'b1, 1'b0, 5'b01000, 16'h0000, 1'b1, 1'b0, 4'h0, 32'd0};
        vecs[6]  = '{1'b1, 1'b1, 5'b10000, 16'h0000, 1'b1, 1'b1, 4'h1, 32'd1};
        vecs[7]  = '{1'b1, 1'b0, 5'b01000, 16'h0000, 1'b1, 1'b1, 4'h0, 32'd1};
        vecs[8]  = '{1'b1, 1'b0, 5'b01000, 16'h0000, 1'b1, 1'b0, 4'h0, 32'd1};
        vecs[9]  = '{1'b1, 1'b1, 5'b10000, 16'h0000, 1'b1, 1'b1, 4'h3, 32'd2};
        vecs[10] = '{1'b1, 1'b1, 5'b01000, 16'h0000, 1'b1, 1'b1, 4'h0, 32'd2};
        vecs[11] = '{1'b1, 1'b1, 5'b01000, 16'h0000, 1'b1, 1'b0, 4'h0, 32'd2};
        vecs[12] = '{1'b1, 1'b1, 5'b10000, 16'h0000, 1'b1, 1'b1, 4'h1, 32'd3};
        vecs[13] = '{1'b1, 1'b0, 5'b01000, 16'h0000, 1'b1, 1'b1, 4'h0, 32'd3};
        vecs[14] = '{1'b1, 1'b0, 5'b01000, 16'h0000, 1'b1, 1'b0, 4'h0, 32'd3};

        halt_seq[0] = {5'b10011, 16'h0000};
        halt_seq[1] = {5'b10000, 16'h0000};
        halt_seq[2] = {5'b10001, 16'h0007};
        halt_seq[3] = {5'b01000, 16'h0000};
        halt_seq[4] = {5'b10001, 16'h0008};
        halt_seq[5] = {5'b01000, 16'h0000};

        reset = 1'b1;
        run = 1'b0;
        snap_req = 1'b0;
        tm_bus.tm_irq = 1'b0;
        live_cnt = 32'd0;
        #1;
        check_reset_vals("reset0");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            run = vecs[i].run;
            tm_bus.tm_irq = vecs[i].irq;
            @(posedge clk); #1;
            check($sformatf("vec%0d.bus", i), {27'd0, bus5()}, {27'd0, vecs[i].bus});
            check($sformatf("vec%0d.wdata", i), {16'd0, tm_bus.tm_writedata}, {16'd0, vecs[i].wd});
            check($sformatf("vec%0d.running", i), {31'd0, running}, {31'd0, vecs[i].running});
            check($sformatf("vec%0d.busy", i), {31'd0, busy}, {31'd0, vecs[i].busy});
            check($sformatf("vec%0d.tick", i), {28'd0, tick}, {28'd0, vecs[i].tick});
            check($sformatf("vec%0d.count", i), tick_count, vecs[i].cnt);
        end
        tm_bus.tm_irq = 1'b0;

        for (int n = 4; n <= 10; n++) do_timeout(n, n);
        check("ten.ch0", tick_seen[0], 10);
        check("ten.ch1", tick_seen[1], 5);
        check("ten.ch2", tick_seen[2], 2);
        check("ten.ch3", tick_seen[3], 1);

        do_snap("snap42", 32'h0000_0042);
        do_snap("snapwide", 32'h1234_5678);

        // irq and snap_req together: ack first, snapshot three cycles later.
        base = ack_writes;
        @(negedge clk);
        live_cnt = 32'hCAFE_0001;
        tm_bus.tm_irq = 1'b1;
        snap_req = 1'b1;
        @(posedge clk); #1;
        tm_bus.tm_irq = 1'b0;
        snap_req = 1'b0;
        check("both.ack_bus", {27'd0, bus5()}, 32'h10);
        check("both.count", tick_count, 32'd11);
        @(posedge clk); #1;
        check("both.gap_bus", {27'd0, bus5()}, 32'h08);
        @(posedge clk); #1;
        check("both.run_bus", {27'd0, bus5()}, 32'h08);
        @(posedge clk); #1;
        check("both.snap_w_bus", {27'd0, bus5()}, 32'h14);
        snap_tail("both", 32'hCAFE_0001);
        check("both.single_ack", ack_writes - base, 1);
        check("both.count_once", tick_count, 32'd11);

        @(negedge clk);
        force dut.tick_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.tick_count_q;
        do_timeout(12, 32'd0);

        @(negedge clk);
        run = 1'b0;
        @(posedge clk); #1;
        check("halt.bus", {27'd0, bus5()}, 32'h11);
        check("halt.wdata", {16'd0, tm_bus.tm_writedata}, 32'h0008);
        check("halt.busy", {31'd0, busy}, 32'd1);
        @(posedge clk); #1;
        check("idle.bus", {27'd0, bus5()}, 32'h08);
        check("idle.run_busy", {30'd0, running, busy}, 32'd0);
        check("idle.count_hold", tick_count, 32'd0);

        @(negedge clk);
        tm_bus.tm_irq = 1'b1;
        snap_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            snap_req = 1'b0;
            check($sformatf("idle_irq%0d.cs", k), {31'd0, tm_bus.tm_chipselect}, 32'd0);
        end
        tm_bus.tm_irq = 1'b0;

        // run pulse dropped during PL_W: init completes, then halt.
        @(negedge clk);
        run = 1'b1;
        @(posedge clk); #1;
        check("pulse.stop_bus", {27'd0, bus5()}, 32'h11);
        @(posedge clk); #1;
        check("pulse.pl_bus", {27'd0, bus5()}, 32'h12);
        run = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            check($sformatf("pulse%0d.access", k), {11'd0, bus5(), tm_bus.tm_writedata},
                  {11'd0, halt_seq[k]});
        end
        check("pulse.idle_busy", {31'd0, busy}, 32'd0);

        // Restart: dropped idle snap_req must not fire, channel counters restart.
        @(negedge clk);
        run = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("restart.running", {31'd0, running}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            check($sformatf("restart%0d.no_snap", k), {31'd0, tm_bus.tm_chipselect}, 32'd0);
        end
        do_timeout(1, 32'd1);
        do_timeout(2, 32'd2);

        // Async reset in SNAP_RL.
        @(negedge clk);
        live_cnt = 32'h0BAD_F00D;
        snap_req = 1'b1;
        @(posedge clk); #1;
        snap_req = 1'b0;
        find_snap_w("rst");
        @(posedge clk); #1;
        check("rst.rl_bus", {27'd0, bus5()}, 32'h1C);
        #2;
        reset = 1'b1;
        #1;
        check_reset_vals("reset_mid");
        @(negedge clk);
        reset = 1'b0;
        run = 1'b0;
        repeat (2) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
